// File: rtl/booth_cpa_pkg.sv
// booth_cpa_pkg: width helpers shared by the segmented carry-propagate pipeline.
package booth_cpa_pkg;
    function automatic int pw(input int width);
        return 2 * width;
    endfunction
    function automatic int n_stages(input int width, input int seg_w);
        return (2 * width) / seg_w;
    endfunction
    function automatic int occ_w(input int width, input int seg_w);
        return $clog2((2 * width) / seg_w + 1);
    endfunction
endpackage

// File: rtl/booth_cpa_pipe_stage.sv
// cpa_seg_stage: resolves one SEG_W slice of the carry-save pair and registers the partial result.
module cpa_seg_stage import booth_cpa_pkg::*; #(
    parameter int PW = 16,
    parameter int SEG_W = 4,
    parameter int K = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load,
    input  logic          in_v,
    input  logic [PW-1:0] in_res,
    input  logic [PW-1:0] in_car,
    input  logic          in_cin,
    output logic          v,
    output logic [PW-1:0] res,
    output logic [PW-1:0] car,
    output logic          cin
);
    localparam int LO = K * SEG_W;
    logic [SEG_W:0]  seg;
    logic [PW-1:0]   nres;
    // Bits below LO are already resolved; bits above stay raw sum for later stages.
    always_comb begin
        seg = {1'b0, in_res[LO+:SEG_W]} + {1'b0, in_car[LO+:SEG_W]} + {{SEG_W{1'b0}}, in_cin};
        nres = in_res;
        nres[LO+:SEG_W] = seg[SEG_W-1:0];
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v   <= 1'b0;
            res <= '0;
            car <= '0;
            cin <= 1'b0;
        end else if (load) begin
            v   <= in_v;
            res <= nres;
            car <= in_car;
            cin <= seg[SEG_W];
        end
    end
endmodule

// File: rtl/booth_cpa_pipe.sv
// booth_cpa_pipe: segmented pipelined CPA turning a Booth carry-save pair into the product,
// with bubble-collapsing valid/ready flow control.
module booth_cpa_pipe import booth_cpa_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int SEG_W = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [pw(WIDTH)-1:0]             sum_in,
    input  logic [pw(WIDTH)-1:0]             carry_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [pw(WIDTH)-1:0]             product,
    output logic [occ_w(WIDTH, SEG_W)-1:0]   occupancy
);
    localparam int PW = pw(WIDTH);
    localparam int STAGES = n_stages(WIDTH, SEG_W);
    localparam int OW = occ_w(WIDTH, SEG_W);
    logic [STAGES:0] vs;
    logic [STAGES:0] ld;
    logic [PW-1:0]   res [STAGES+1];
    logic [PW-1:0]   car [STAGES+1];
    logic            cin [STAGES+1];
    assign vs[0]  = in_valid;
    assign res[0] = sum_in;
    assign car[0] = carry_in;
    assign cin[0] = 1'b0;
    // A stage loads if it is empty or its successor is loading; the top carry is dropped.
    always_comb begin
        ld = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) ld[k] = !vs[k+1] || ld[k+1];
    end
    always_comb begin
        occupancy = '0;
        for (int k = 1; k <= STAGES; k++) occupancy = occupancy + OW'(vs[k]);
    end
    assign in_ready  = ld[0];
    assign out_valid = vs[STAGES];
    assign product   = res[STAGES];
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        cpa_seg_stage #(.PW(PW), .SEG_W(SEG_W), .K(k)) u_stg (
            .CLK    (CLK),
            .RST    (RST),
            .load   (ld[k]),
            .in_v   (vs[k]),
            .in_res (res[k]),
            .in_car (car[k]),
            .in_cin (cin[k]),
            .v      (vs[k+1]),
            .res    (res[k+1]),
            .car    (car[k+1]),
            .cin    (cin[k+1])
        );
    end
endmodule
